// File: rtl/uart_async_tx.sv
// Host-programmable UART transmitter: register bus in, 4-entry byte FIFO,
// baud FSM serialising start / 8 data LSB-first / optional parity / stop.
module uart_async_tx #(
  parameter int unsigned                 padd_size     = 24,
  parameter int unsigned                 cmd_size      = 3,
  parameter int unsigned                 data_size     = 32,
  parameter logic [padd_size-1:0]        base_addr     = 24'h080030,
  parameter int unsigned                 fifo_depth    = 4,
  parameter int unsigned                 fifo_ptr_size = 2,
  parameter logic [15:0]                 div_default   = 16
) (
  input  logic                 clk0,
  input  logic                 reset,
  input  logic [padd_size-1:0] host_addr,
  input  logic [cmd_size-1:0]  host_cmd,
  input  logic [data_size-1:0] host_datain,
  output logic [data_size-1:0] host_dataout,
  output logic                 ser_txd,
  output logic                 tx_busy,
  output logic                 tx_irq
);

  localparam int unsigned cnt_w = fifo_ptr_size + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t                   state_q, state_d;
  logic [7:0]               mem_q [fifo_depth];
  logic [7:0]               mem_d [fifo_depth];
  logic [fifo_ptr_size-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]         count_q, count_d;
  logic [3:0]               ctrl_q, ctrl_d;
  logic [15:0]              div_q, div_d, div_lat_q, div_lat_d;
  logic [15:0]              baud_cnt_q, baud_cnt_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic                     par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic                     ovf_q, ovf_d;
  logic                     ser_txd_q, ser_txd_d;
  logic [data_size-1:0]     dout_q, dout_d;

  logic [padd_size-1:0] reg_off;
  logic [1:0]           reg_sel;
  logic                 in_range, wr_en, rd_en;
  logic                 empty, full, bit_end, pop, push;
  logic [7:0]           head;
  logic                 unused_bits;

  assign reg_off  = host_addr - base_addr;
  assign reg_sel  = reg_off[1:0];
  assign in_range = (reg_off[padd_size-1:2] == '0);
  assign wr_en    = in_range && (host_cmd == cmd_size'(2));
  assign rd_en    = in_range && (host_cmd == cmd_size'(1));
  assign empty    = (count_q == '0);
  assign full     = (count_q == cnt_w'(fifo_depth));
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (baud_cnt_q == div_lat_q - 16'd1);
  assign unused_bits = ^host_datain[data_size-1:16];

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    div_lat_d  = div_lat_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    ovf_d      = ovf_q;
    ser_txd_d  = ser_txd_q;
    dout_d     = dout_q;

    // A pop happens only from IDLE or at the last cycle of STOP.
    pop  = ctrl_q[0] && !empty &&
           ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_end));
    push = wr_en && (reg_sel == 2'd0) && (!full || pop);

    if (wr_en) begin
      case (reg_sel)
        2'd0: if (!push) ovf_d = 1'b1;
        2'd1: ctrl_d = host_datain[3:0];
        2'd2: div_d  = host_datain[15:0];
        default: if (host_datain[3]) ovf_d = 1'b0;
      endcase
    end

    if (rd_en) begin
      case (reg_sel)
        2'd0:    dout_d = '0;
        2'd1:    dout_d = data_size'(ctrl_q);
        2'd2:    dout_d = data_size'(div_q);
        default: dout_d = data_size'({count_q, ovf_q, state_q != ST_IDLE, full, empty});
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = host_datain[7:0];
      wr_ptr_d        = wr_ptr_q + fifo_ptr_size'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + fifo_ptr_size'(1);
    if (push && !pop)      count_d = count_q + cnt_w'(1);
    else if (pop && !push) count_d = count_q - cnt_w'(1);

    if (state_q != ST_IDLE) baud_cnt_d = baud_cnt_q + 16'd1;

    case (state_q)
      ST_START: if (bit_end) begin
        state_d    = ST_DATA;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        ser_txd_d  = shift_q[0];
      end
      ST_DATA: if (bit_end) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == 3'd7) begin
          state_d   = par_en_q ? ST_PARITY : ST_STOP;
          ser_txd_d = par_en_q ? par_bit_q : 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = {1'b0, shift_q[7:1]};
          ser_txd_d = shift_q[1];
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d    = ST_STOP;
        baud_cnt_d = '0;
        ser_txd_d  = 1'b1;
      end
      ST_STOP: if (bit_end) begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
        ser_txd_d  = 1'b1;
      end
      default: ser_txd_d = 1'b1;
    endcase

    // Frame parameters are latched at pop so host writes only affect later frames.
    if (pop) begin
      state_d    = ST_START;
      baud_cnt_d = '0;
      shift_d    = head;
      div_lat_d  = (div_q == '0) ? 16'd1 : div_q;
      par_en_d   = ctrl_q[1];
      par_bit_d  = (^head) ^ ctrl_q[2];
      ser_txd_d  = 1'b0;
    end
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      for (int unsigned i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ctrl_q     <= '0;
      div_q      <= div_default;
      div_lat_q  <= 16'd1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      ovf_q      <= 1'b0;
      ser_txd_q  <= 1'b1;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      div_lat_q  <= div_lat_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      ovf_q      <= ovf_d;
      ser_txd_q  <= ser_txd_d;
      dout_q     <= dout_d;
    end
  end

  assign host_dataout = dout_q;
  assign ser_txd      = ser_txd_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_irq       = ctrl_q[3] && empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_async_tx.sv
// Directed bench for uart_async_tx: register access, frame shape and timing,
// parity, FIFO overflow, back-to-back frames, DIV latching, irq and reset.
module tb_uart_async_tx;

  localparam logic [23:0] BASE = 24'h080030;

  logic        clk0 = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] host_addr = '0;
  logic [2:0]  host_cmd = '0;
  logic [31:0] host_datain = '0;
  logic [31:0] host_dataout;
  logic        ser_txd, tx_busy, tx_irq;

  int n_checks = 0;
  int n_errs   = 0;

  uart_async_tx #(.base_addr(BASE), .div_default(16'd16)) dut (
    .clk0(clk0), .reset(reset), .host_addr(host_addr), .host_cmd(host_cmd),
    .host_datain(host_datain), .host_dataout(host_dataout),
    .ser_txd(ser_txd), .tx_busy(tx_busy), .tx_irq(tx_irq)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [23:0] addr, input logic [31:0] data);
    host_addr = addr; host_datain = data; host_cmd = 3'b010;
    @(posedge clk0); #1;
    host_cmd = 3'b000;
  endtask

  task automatic rd(input logic [23:0] addr, output logic [31:0] data);
    host_addr = addr; host_cmd = 3'b001;
    @(posedge clk0); #1;
    host_cmd = 3'b000;
    data = host_dataout;
  endtask

  // Called just after the edge that starts the frame.
  task automatic expect_frame(input logic [7:0] b, input int div, input logic par_en, input logic odd);
    logic [10:0] bits;
    int nb;
    nb = par_en ? 11 : 10;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = par_en ? ((^b) ^ odd) : 1'b1;
    bits[10]  = 1'b1;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < div; j++) begin
        @(negedge clk0);
        check($sformatf("ser b%0d c%0d", i, j), 32'(ser_txd), 32'(bits[i]));
        if (i == 0 && j == 0) begin
          check("busy_in_frame", 32'(tx_busy), 32'd1);
          check("irq_in_frame", 32'(tx_irq), 32'd0);
        end
      end
    end
  endtask

  task automatic expect_idle();
    @(negedge clk0);
    check("idle_busy", 32'(tx_busy), 32'd0);
    check("idle_ser", 32'(ser_txd), 32'd1);
  endtask

  logic [31:0] r;

  initial begin
    #23 reset = 1'b0;
    @(negedge clk0);
    check("rst_ser", 32'(ser_txd), 32'd1);
    check("rst_dout", host_dataout, 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_irq", 32'(tx_irq), 32'd0);
    rd(BASE + 24'd3, r); check("rst_status", r, 32'h01);
    rd(BASE + 24'd2, r); check("rst_div", r, 32'd16);
    rd(BASE + 24'd1, r); check("rst_ctrl", r, 32'd0);

    wr(BASE + 24'd1, 32'hFFFF_FFF1);
    rd(BASE + 24'd1, r); check("ctrl_upper_zero", r, 32'h1);
    wr(BASE + 24'd4, 32'h0);
    wr(BASE - 24'd1, 32'h0);
    rd(BASE + 24'd1, r); check("ctrl_oor_ignored", r, 32'h1);
    rd(BASE + 24'd7, r); check("dout_hold_oor", r, 32'h1);
    wr(BASE + 24'd2, 32'd4);
    rd(BASE + 24'd2, r); check("div_rb", r, 32'd4);
    rd(BASE, r); check("data_reads_zero", r, 32'd0);

    // 0xA5, no parity, DIV 4
    wr(BASE, 32'hA5);
    @(posedge clk0);
    expect_frame(8'hA5, 4, 1'b0, 1'b0);
    expect_idle();

    wr(BASE + 24'd1, 32'h3);
    wr(BASE, 32'hA5);
    @(posedge clk0);
    expect_frame(8'hA5, 4, 1'b1, 1'b0);
    expect_idle();

    wr(BASE + 24'd1, 32'h7);
    wr(BASE, 32'hA5);
    @(posedge clk0);
    expect_frame(8'hA5, 4, 1'b1, 1'b1);
    expect_idle();

    // Overflow, then back-to-back drain
    wr(BASE + 24'd1, 32'h0);
    for (int k = 1; k <= 5; k++) wr(BASE, 32'(k));
    rd(BASE + 24'd3, r); check("status_full_ovf", r, 32'h4A);
    wr(BASE + 24'd1, 32'h1);
    @(posedge clk0);
    for (int k = 1; k <= 4; k++) expect_frame(8'(k), 4, 1'b0, 1'b0);
    expect_idle();
    rd(BASE + 24'd3, r); check("status_drained", r, 32'h09);
    wr(BASE + 24'd3, 32'h8);
    rd(BASE + 24'd3, r); check("status_ovf_clr", r, 32'h01);

    // DIV 0 behaves as 1
    wr(BASE + 24'd2, 32'd0);
    wr(BASE, 32'h3C);
    @(posedge clk0);
    expect_frame(8'h3C, 1, 1'b0, 1'b0);
    expect_idle();

    // DIV change mid-frame only affects the next frame
    wr(BASE + 24'd1, 32'h0);
    wr(BASE + 24'd2, 32'd2);
    wr(BASE, 32'h5A);
    wr(BASE, 32'hC3);
    wr(BASE + 24'd1, 32'h1);
    @(posedge clk0);
    fork
      expect_frame(8'h5A, 2, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk0);
        wr(BASE + 24'd2, 32'd8);
      end
    join
    expect_frame(8'hC3, 8, 1'b0, 1'b0);
    expect_idle();

    // irq
    wr(BASE + 24'd2, 32'd4);
    wr(BASE + 24'd1, 32'h9);
    check("irq_idle_empty", 32'(tx_irq), 32'd1);
    wr(BASE, 32'h96);
    check("irq_fifo_nonempty", 32'(tx_irq), 32'd0);
    @(posedge clk0);
    expect_frame(8'h96, 4, 1'b0, 1'b0);
    expect_idle();
    check("irq_after_frame", 32'(tx_irq), 32'd1);

    // Reset mid-frame
    wr(BASE + 24'd1, 32'h1);
    wr(BASE, 32'h81);
    wr(BASE, 32'h42);
    repeat (2) @(negedge clk0);
    check("pre_rst_start_bit", 32'(ser_txd), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("async_rst_ser", 32'(ser_txd), 32'd1);
    check("async_rst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk0);
    reset = 1'b0;
    rd(BASE + 24'd3, r); check("rst_fifo_discard", r, 32'h01);
    @(negedge clk0);
    check("rst_ser_stays", 32'(ser_txd), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
